color_cycler: RTL and testbench

- Parametrised colour-sequence generator for the VGA display, e.g. border or background colour.
- Produces packed RGB colour words of CW bits per channel. The colour advances on a programmable clock-divider tick or on an external bump strobe.
- Supports four modes: free-running wrap, per-channel bounce (triangle), hold, and pseudo-random.
- Sits between game logic (bump, mode select) and the pixel/colour mux feeding the VGA output.

---
 rtl/color_cycler.sv | 130 +++++++++++++
 tb/tb_color_cycler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_cycler.sv
`default_nettype none
// ============================================================================
// Module   : color_cycler
// Purpose  : Packed RGB colour-sequence generator (wrap/bounce/hold/random)
//            advanced by a clock-divider tick or an external bump strobe.
// Revision : 1.0  initial release
// ============================================================================
module color_cycler #(
    parameter int              CW     = 4,
    parameter int              DIV    = 100000000,
    parameter int              DIVW   = 28,
    parameter int              STEP_R = 1,
    parameter int              STEP_G = 4,
    parameter int              STEP_B = 7,
    parameter logic [3*CW-1:0] SEED   = '0
) (
    input  logic              CLK_100MHz,
    input  logic              RST_N,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              bump,
    output logic [3*CW-1:0]   color,
    output logic              tick
);

    localparam logic [1:0]      C_MODE_WRAP   = 2'b00;
    localparam logic [1:0]      C_MODE_BOUNCE = 2'b01;
    localparam logic [1:0]      C_MODE_HOLD   = 2'b10;
    localparam logic [1:0]      C_MODE_RANDOM = 2'b11;
    localparam logic [15:0]     C_LFSR_INIT   = 16'hACE1;
    localparam logic [15:0]     C_LFSR_TAPS   = 16'hB400;
    localparam logic [DIVW-1:0] C_TERM        = DIVW'(DIV - 1);
    localparam logic [CW-1:0]   C_STEP_R      = CW'(STEP_R);
    localparam logic [CW-1:0]   C_STEP_G      = CW'(STEP_G);
    localparam logic [CW-1:0]   C_STEP_B      = CW'(STEP_B);
    localparam logic [CW:0]     C_MAX_EXT     = {1'b0, {CW{1'b1}}};

    logic [DIVW-1:0] r_cnt;
    logic [3*CW-1:0] r_color;
    logic [2:0]      r_dn;       // per-channel direction, 1 = descending
    logic            r_tick;
    logic [15:0]     r_lfsr;

    logic            w_term;
    logic            w_adv;
    logic [15:0]     w_lfsr_next;
    logic [CW:0]     w_ch_r;
    logic [CW:0]     w_ch_g;
    logic [CW:0]     w_ch_b;
    logic [3*CW-1:0] w_next_color;
    logic [2:0]      w_next_dn;

    // Returns {next_dir_down, next_value} for one channel.
    function automatic logic [CW:0] f_chan(
        input logic [CW-1:0] v,
        input logic          dn,
        input logic [CW-1:0] s,
        input logic [CW-1:0] rnd,
        input logic [1:0]    m
    );
        logic [CW:0]   sum;
        logic [CW-1:0] nv;
        logic          nd;
        sum = {1'b0, v} + {1'b0, s};
        nv  = v;
        nd  = dn;
        case (m)
            C_MODE_WRAP: nv = sum[CW-1:0];
            C_MODE_BOUNCE: begin
                if (!dn) begin
                    if (sum >= C_MAX_EXT) begin
                        nv = {CW{1'b1}};
                        nd = 1'b1;
                    end else begin
                        nv = sum[CW-1:0];
                    end
                end else begin
                    if (v <= s) begin
                        nv = '0;
                        nd = 1'b0;
                    end else begin
                        nv = v - s;
                    end
                end
            end
            C_MODE_HOLD: nv = v;
            C_MODE_RANDOM: nv = rnd;
        endcase
        return {nd, nv};
    endfunction

    always_comb begin
        w_term       = en && (r_cnt == C_TERM);
        w_adv        = en && (w_term || bump);
        w_lfsr_next  = (r_lfsr >> 1) ^ (r_lfsr[0] ? C_LFSR_TAPS : 16'h0000);
        w_ch_r       = f_chan(r_color[CW-1:0],      r_dn[0], C_STEP_R, r_lfsr[CW-1:0],      mode);
        w_ch_g       = f_chan(r_color[2*CW-1:CW],   r_dn[1], C_STEP_G, r_lfsr[2*CW-1:CW],   mode);
        w_ch_b       = f_chan(r_color[3*CW-1:2*CW], r_dn[2], C_STEP_B, r_lfsr[3*CW-1:2*CW], mode);
        w_next_color = {w_ch_b[CW-1:0], w_ch_g[CW-1:0], w_ch_r[CW-1:0]};
        w_next_dn    = {w_ch_b[CW], w_ch_g[CW], w_ch_r[CW]};
    end

    // A bump restarts the divider so the next periodic advance is a full period away.
    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt   <= '0;
            r_color <= SEED;
            r_dn    <= '0;
            r_tick  <= 1'b0;
            r_lfsr  <= C_LFSR_INIT;
        end else begin
            r_lfsr <= w_lfsr_next;
            r_tick <= w_adv;
            if (!en || w_adv) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DIVW'(1);
            end
            if (w_adv) begin
                r_color <= w_next_color;
                r_dn    <= w_next_dn;
            end
        end
    end

    assign color = r_color;
    assign tick  = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_color_cycler.sv
`default_nettype none
// ============================================================================
// Module   : tb_color_cycler
// Purpose  : Scoreboard bench for color_cycler (DIV=4, CW=4, default steps).
// Revision : 1.0  initial release
// ============================================================================
module tb_color_cycler;

    localparam int DIV = 4;
    localparam int CW  = 4;

    logic        clk;
    logic        RST_N;
    logic        en;
    logic [1:0]  mode;
    logic        bump;
    logic [11:0] color;
    logic        tick;

    color_cycler #(
        .CW(CW), .DIV(DIV), .DIVW(3),
        .STEP_R(1), .STEP_G(4), .STEP_B(7), .SEED(12'h000)
    ) dut (
        .CLK_100MHz(clk), .RST_N(RST_N), .en(en), .mode(mode),
        .bump(bump), .color(color), .tick(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int          m_cnt;
    int          m_v[3];
    bit          m_up[3];
    int          m_step[3] = '{1, 4, 7};
    logic [15:0] m_lfsr;
    bit          m_term, m_adv;
    bit          exp_tick;
    logic [11:0] exp_q[$];

    always @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            m_cnt = 0;
            for (int c = 0; c < 3; c++) begin m_v[c] = 0; m_up[c] = 1'b1; end
            m_lfsr   = 16'hACE1;
            exp_tick = 1'b0;
            exp_q.delete();
        end else begin
            m_term = en && (m_cnt == DIV - 1);
            m_adv  = en && (m_term || bump);
            if (m_adv) begin
                for (int c = 0; c < 3; c++) begin
                    case (mode)
                        2'd0: m_v[c] = (m_v[c] + m_step[c]) % 16;
                        2'd1: begin
                            if (m_up[c]) begin
                                if (m_v[c] + m_step[c] >= 15) begin m_v[c] = 15; m_up[c] = 1'b0; end
                                else m_v[c] = m_v[c] + m_step[c];
                            end else begin
                                if (m_v[c] <= m_step[c]) begin m_v[c] = 0; m_up[c] = 1'b1; end
                                else m_v[c] = m_v[c] - m_step[c];
                            end
                        end
                        2'd2: ;
                        default: m_v[c] = int'((m_lfsr >> (4 * c)) & 16'h000F);
                    endcase
                end
                exp_q.push_back({m_v[2][3:0], m_v[1][3:0], m_v[0][3:0]});
            end
            m_cnt    = (!en || m_adv) ? 0 : m_cnt + 1;
            m_lfsr   = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            exp_tick = m_adv;
        end
    end

    // ---------------- monitor ----------------
    logic [11:0] mon_exp;
    always @(posedge clk) begin
        #1;
        check("tick_vs_model", {31'd0, tick}, {31'd0, exp_tick});
        if (tick) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL tick_without_expect: got tick=1 color=%h expected no tick", color);
            end else begin
                mon_exp = exp_q.pop_front();
                check("color_on_tick", {20'd0, color}, {20'd0, mon_exp});
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ticks(input int n);
        int seen;
        int guard;
        seen  = 0;
        guard = 0;
        while (seen < n && guard < 100 * n) begin
            @(negedge clk);
            guard++;
            if (tick) seen++;
        end
        if (seen < n) check("tick_timeout", seen, n);
    endtask

    task automatic cycles_to_tick(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tick && k < 50);
    endtask

    function automatic logic [11:0] wrap1(input logic [11:0] c);
        logic [3:0] r, g, b;
        r = c[3:0] + 4'd1;
        g = c[7:4] + 4'd4;
        b = c[11:8] + 4'd7;
        return {b, g, r};
    endfunction

    int exp_g[9] = '{4, 8, 12, 15, 11, 7, 3, 0, 4};
    int exp_b[7] = '{7, 14, 15, 8, 1, 0, 7};
    int seq_r[16];
    int seq_g[16];
    int seq_b[16];
    int nt;
    int k;
    logic [11:0] c0;

    // ---------------- stimulus ----------------
    initial begin
        RST_N = 1'b0; en = 1'b0; mode = 2'b00; bump = 1'b0;
        #3;
        check("reset_color", {20'd0, color}, 32'h000);
        check("reset_tick", {31'd0, tick}, 32'd0);
        @(negedge clk);
        RST_N = 1'b1; en = 1'b1;

        // WRAP
        wait_ticks(1);  check("wrap_adv1",  {20'd0, color}, 32'h741);
        wait_ticks(3);  check("wrap_adv4",  {20'd0, color}, 32'hC04);
        wait_ticks(12); check("wrap_adv16", {20'd0, color}, 32'h000);

        // BOUNCE from zero, all directions up
        mode = 2'b01;
        for (int i = 0; i < 16; i++) begin
            wait_ticks(1);
            seq_r[i] = int'(color[3:0]);
            seq_g[i] = int'(color[7:4]);
            seq_b[i] = int'(color[11:8]);
        end
        for (int i = 0; i < 9; i++) check($sformatf("bounce_g%0d", i), seq_g[i], exp_g[i]);
        for (int i = 0; i < 7; i++) check($sformatf("bounce_b%0d", i), seq_b[i], exp_b[i]);
        check("bounce_r_top",  seq_r[14], 15);
        check("bounce_r_down", seq_r[15], 14);

        // HOLD: ticks continue, colour frozen
        mode = 2'b10;
        c0 = color;
        nt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (tick) nt++;
        end
        check("hold_ticks", nt, 3);
        check("hold_color", {20'd0, color}, {20'd0, c0});
        mode = 2'b00;
        wait_ticks(1);
        check("hold_exit_wrap", {20'd0, color}, {20'd0, wrap1(c0)});

        // bump at counter=1
        cyc(1);
        c0 = color;
        bump = 1'b1;
        @(negedge clk);
        bump = 1'b0;
        check("bump1_tick",  {31'd0, tick}, 32'd1);
        check("bump1_color", {20'd0, color}, {20'd0, wrap1(c0)});
        cycles_to_tick(k);
        check("bump1_next_period", k, 4);

        // bump coinciding with term
        cyc(3);
        c0 = color;
        bump = 1'b1;
        @(negedge clk);
        bump = 1'b0;
        check("bump3_tick",  {31'd0, tick}, 32'd1);
        check("bump3_single", {20'd0, color}, {20'd0, wrap1(c0)});
        cycles_to_tick(k);
        check("bump3_next_period", k, 4);

        // bump while disabled
        en = 1'b0;
        cyc(2);
        c0 = color;
        bump = 1'b1;
        @(negedge clk);
        bump = 1'b0;
        nt = 0;
        for (int i = 0; i < 6; i++) begin
            if (tick) nt++;
            @(negedge clk);
        end
        check("bump_en0_ticks", nt, 0);
        check("bump_en0_color", {20'd0, color}, {20'd0, c0});
        en = 1'b1;

        // Mixed random modes, bumps and enable drops
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (i % 40 == 0) mode = 2'($urandom_range(0, 3));
            bump = ($urandom_range(0, 15) == 0);
            en   = ($urandom_range(0, 31) != 0);
        end

        // RANDOM mode long run
        mode = 2'b11;
        for (int i = 0; i < 66000; i++) begin
            @(negedge clk);
            bump = ($urandom_range(0, 15) == 0);
            en   = ($urandom_range(0, 63) != 0);
        end
        bump = 1'b0; en = 1'b1;

        // Asynchronous reset mid-BOUNCE
        mode = 2'b01;
        wait_ticks(5);
        @(posedge clk);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_rst_color", {20'd0, color}, 32'h000);
        check("async_rst_tick",  {31'd0, tick}, 32'd0);
        cyc(2);
        RST_N = 1'b1;
        wait_ticks(1);
        check("post_rst_dirs_up", {20'd0, color}, 32'h741);

        cyc(3);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
